// File: rtl/tnn_seq_neuron.sv
// Sequential ternary-weight neuron: accumulates +/- input elements LANES per cycle,
// then registers the signed margin and its threshold class against BIAS.

module tnn_seq_neuron_lane #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 6
) (
  input  logic             en,
  input  logic             pos,
  input  logic [IN_W-1:0]  elem,
  output logic [ACC_W-1:0] term
);
  logic [ACC_W-1:0] mag;

  // zero-extend before negating so every element is treated as unsigned
  assign mag  = ACC_W'(elem);
  assign term = !en ? '0 : (pos ? mag : -mag);
endmodule

module tnn_seq_neuron #(
  parameter int              N_IN     = 7,
  parameter int              IN_W     = 2,
  parameter int              LANES    = 1,
  parameter logic [N_IN-1:0] POS_MASK = 7'b0011001,
  parameter int              BIAS     = 0,
  localparam int             ACC_W    = IN_W + $clog2(N_IN) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_class,
  output logic [ACC_W-1:0]     out_margin
);
  localparam int IDX_W = $clog2(N_IN + LANES) + 1;
  localparam logic signed [ACC_W-1:0] BIAS_V = ACC_W'(BIAS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                  state;
  logic [IDX_W-1:0]            idx;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     sum;
  logic [N_IN*IN_W-1:0]        sample;
  logic [LANES-1:0][ACC_W-1:0] term;
  logic                        last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (int'(idx) + LANES >= N_IN);

  // lane j handles element idx+j; lanes past the last element contribute zero
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [IDX_W-1:0] e;
    assign e = idx + IDX_W'(j);

    tnn_seq_neuron_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .en   (int'(e) < N_IN),
      .pos  (1'(POS_MASK >> e)),
      .elem (IN_W'(sample >> (e * IN_W))),
      .term (term[j])
    );
  end

  always_comb begin
    sum = acc;
    for (int j = 0; j < LANES; j++) sum = sum + $signed(term[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      sample     <= '0;
      out_class  <= 1'b0;
      out_margin <= '0;
    end else if (flush) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sample <= in_data;
          acc    <= '0;
          idx    <= '0;
          state  <= ACCUM;
        end
        ACCUM: begin
          acc <= sum;
          idx <= idx + IDX_W'(LANES);
          if (last) begin
            out_margin <= sum;
            out_class  <= (sum >= BIAS_V);
            state      <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tnn_seq_neuron.sv
// Scoreboard bench: drivers push expected {class, margin, arrival cycle}; monitors pop on handshake.

module tb_tnn_seq_neuron;
  typedef struct {
    logic        cls;
    int          m;
    int          cyc;
  } exp_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 1;
  logic [13:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_class;
  logic [5:0]  a_out_margin;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 1;
  logic [13:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_class;
  logic [5:0]  b_out_margin;

  int checks = 0, errors = 0, cyc = 0;
  exp_t q0[$], q1[$];
  bit a_seen = 0, b_seen = 0;

  tnn_seq_neuron dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_class(a_out_class), .out_margin(a_out_margin)
  );

  tnn_seq_neuron #(.LANES(3), .BIAS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_class(b_out_class), .out_margin(b_out_margin)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitors: latency on rising out_valid, payload on handshake, stray valid when nothing expected
  always @(negedge clk) begin
    if (a_out_valid && !a_seen) begin
      a_seen = 1;
      if (q0.size() == 0) chk("a_stray_valid", 1, 0);
      else chk("a_latency", cyc, q0[0].cyc);
    end
    if (!a_out_valid) a_seen = 0;
    if (a_out_valid && a_out_ready && q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      chk("a_class", int'(a_out_class), int'(e.cls));
      chk("a_margin", int'($signed(a_out_margin)), e.m);
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && !b_seen) begin
      b_seen = 1;
      if (q1.size() == 0) chk("b_stray_valid", 1, 0);
      else chk("b_latency", cyc, q1[0].cyc);
    end
    if (!b_out_valid) b_seen = 0;
    if (b_out_valid && b_out_ready && q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      chk("b_class", int'(b_out_class), int'(e.cls));
      chk("b_margin", int'($signed(b_out_margin)), e.m);
    end
  end

  task automatic send_a(input logic [13:0] d, input logic cls, input int m, input bit push);
    int n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 60) begin @(negedge clk); n++; end
    if (!a_in_ready) begin chk("a_ready_timeout", 0, 1); return; end
    a_in_valid = 1; a_in_data = d;
    @(posedge clk); #1;
    a_in_valid = 0; a_in_data = 14'($urandom);
    if (push) q0.push_back('{cls, m, cyc + 7});
  endtask

  task automatic send_b(input logic [13:0] d, input logic cls, input int m);
    int n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 60) begin @(negedge clk); n++; end
    if (!b_in_ready) begin chk("b_ready_timeout", 0, 1); return; end
    b_in_valid = 1; b_in_data = d;
    @(posedge clk); #1;
    b_in_valid = 0; b_in_data = 14'($urandom);
    q1.push_back('{cls, m, cyc + 3});
  endtask

  task automatic wait_valid_a();
    int n = 0;
    @(negedge clk);
    while (!a_out_valid && n < 60) begin @(negedge clk); n++; end
    if (!a_out_valid) chk("a_valid_timeout", 0, 1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_class", int'(a_out_class), 0);
    chk("rst_out_margin", int'(a_out_margin), 0);
    #1 rst_n = 1;

    // element fields packed {e6,e5,e4,e3,e2,e1,e0}; mask 0011001 makes e0,e3,e4 positive
    send_a(14'b00_00_00_00_00_00_00, 1'b1, 0, 1);
    send_a(14'b00_00_11_11_00_00_11, 1'b1, 9, 1);
    send_a(14'b11_11_00_00_11_11_00, 1'b0, -12, 1);
    send_a(14'b01_01_01_01_01_01_01, 1'b0, -1, 1);
    send_a(14'b00_00_00_00_00_01_10, 1'b1, 1, 1);
    send_a(14'b10_00_01_00_00_00_00, 1'b0, -1, 1);

    // backpressure: result must hold while out_ready is low
    wait_valid_a();
    @(posedge clk); #1 a_out_ready = 0;
    send_a(14'b11_11_11_11_11_11_11, 1'b0, -3, 1);
    wait_valid_a();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", int'(a_out_valid), 1);
      chk("hold_in_ready", int'(a_in_ready), 0);
      chk("hold_margin", int'($signed(a_out_margin)), -3);
      chk("hold_class", int'(a_out_class), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 a_out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", int'(a_in_ready), 1);

    // flush during the third ACCUM cycle
    send_a(14'b00_00_11_11_00_00_11, 1'b1, 9, 0);
    @(posedge clk); @(posedge clk); #1 a_flush = 1;
    @(posedge clk); #1 a_flush = 0;
    @(negedge clk);
    chk("flush_in_ready", int'(a_in_ready), 1);
    chk("flush_out_valid", int'(a_out_valid), 0);
    repeat (10) @(negedge clk);
    send_a(14'b11_11_00_00_11_11_00, 1'b0, -12, 1);

    // asynchronous reset mid-ACCUM, away from any clock edge
    wait_valid_a();
    send_a(14'b11_11_11_11_11_11_11, 1'b0, -3, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 0;
    #1;
    chk("arst_in_ready", int'(a_in_ready), 1);
    chk("arst_out_valid", int'(a_out_valid), 0);
    chk("arst_out_class", int'(a_out_class), 0);
    chk("arst_out_margin", int'(a_out_margin), 0);
    @(negedge clk); #1 rst_n = 1;
    repeat (12) @(negedge clk);
    send_a(14'b00_00_11_11_00_00_11, 1'b1, 9, 1);

    // LANES=3, BIAS=2: threshold boundary around margin == BIAS
    send_b(14'b01_01_01_01_01_01_01, 1'b0, -1);
    send_b(14'b00_00_00_01_00_00_01, 1'b1, 2);
    send_b(14'b00_00_00_00_00_00_01, 1'b0, 1);

    for (int n = 0; n < 100 && (q0.size() + q1.size()) > 0; n++) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
